alsu_param: RTL and testbench

Parametrised two-stage arithmetic/logic/shift unit, the next generation of the team's fixed 3-bit ALSU. Operand width, LED width and error-counter width are parameters. It adds valid tracking through the pipeline, a saturating invalid-operation counter with synchronous clear, and a fixed bypass/invalid priority. It sits between the board switch/button front end and the LED/7-segment drivers.

---
 rtl/alsu_pkg.sv | 35 +++
 rtl/alsu_param_if.sv | 49 ++++
 rtl/alsu_datapath.sv | 89 ++++++++
 rtl/alsu_param.sv | 153 +++++++++++++++
 tb/tb_alsu_param.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_pkg
//  Description : Shared opcode encodings, operand-priority strings and the
//                invalid-operation decode for the parametrised ALSU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alsu_pkg;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MUL    = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;

    // Operand chosen when both bypass flags (or both reduction flags) are set
    localparam string PRIO_A = "A";
    localparam string PRIO_B = "B";

    // Opcodes 6/7 are undefined; reduction only makes sense for AND/XOR
    function automatic logic is_invalid(
        input logic [2:0] opcode,
        input logic       red_op_a,
        input logic       red_op_b
    );
        logic bad_op;
        logic bad_red;
        bad_op  = (opcode == 3'd6) || (opcode == 3'd7);
        bad_red = (red_op_a || red_op_b) && (opcode != OP_AND) && (opcode != OP_XOR);
        return bad_op || bad_red;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alsu_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_param_if
//  Description : Operand/control bus and result bus of the ALSU.
//                master : front end (drives operands, observes results)
//                slave  : ALSU (consumes operands, drives results)
//  Ports       : in_valid, A, B, opcode, cin, serial_in, direction,
//                red_op_A/B, bypass_A/B, err_clr -> out, out_valid, leds,
//                err_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
interface alsu_param_if #(
    parameter int WIDTH = 3,
    parameter int LED_W = 16,
    parameter int ERR_W = 8
);
    localparam int OUT_W = 2 * WIDTH;

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;
    logic             cin;
    logic             serial_in;
    logic             direction;
    logic             red_op_A;
    logic             red_op_B;
    logic             bypass_A;
    logic             bypass_B;
    logic             err_clr;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic [LED_W-1:0] leds;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B, err_clr,
        input  out, out_valid, leds, err_cnt
    );

    modport slave (
        input  in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B, err_clr,
        output out, out_valid, leds, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/alsu_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_datapath
//  Description : Combinational stage-2 result of the ALSU, computed from the
//                stage-1 registers and the current output register.
//  Ports       : a, b, opcode, cin, serial_in, direction, red_op_a/b,
//                bypass_a/b, out_cur (in) -> result, invalid (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module alsu_datapath
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON"
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         opcode,
    input  logic               cin,
    input  logic               serial_in,
    input  logic               direction,
    input  logic               red_op_a,
    input  logic               red_op_b,
    input  logic               bypass_a,
    input  logic               bypass_b,
    input  logic [2*WIDTH-1:0] out_cur,
    output logic [2*WIDTH-1:0] result,
    output logic               invalid
);

    localparam int OUT_W = 2 * WIDTH;

    // Any string other than "B" falls back to A priority
    localparam bit PICK_A  = (INPUT_PRIORITY == PRIO_A) || (INPUT_PRIORITY != PRIO_B);
    localparam bit ADD_CIN = (FULL_ADDER == "ON");

    logic [WIDTH-1:0] byp_opnd;
    logic [WIDTH-1:0] red_opnd;
    logic             red_any;
    logic             cin_eff;
    logic [WIDTH:0]   sum;
    logic [OUT_W-1:0] prod;

    always_comb begin
        byp_opnd = b;
        red_opnd = b;
        if (bypass_a && bypass_b) begin
            byp_opnd = PICK_A ? a : b;
        end else if (bypass_a) begin
            byp_opnd = a;
        end
        if (red_op_a && red_op_b) begin
            red_opnd = PICK_A ? a : b;
        end else if (red_op_a) begin
            red_opnd = a;
        end

        red_any = red_op_a || red_op_b;
        cin_eff = ADD_CIN ? cin : 1'b0;
        sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_eff};
        prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

        result  = '0;
        invalid = 1'b0;

        // Bypass outranks the invalid check, so a bypassed bad opcode is silent
        if (bypass_a || bypass_b) begin
            result = OUT_W'(byp_opnd);
        end else if (is_invalid(opcode, red_op_a, red_op_b)) begin
            invalid = 1'b1;
        end else begin
            case (opcode)
                OP_AND:    result = red_any ? OUT_W'(&red_opnd) : OUT_W'(a & b);
                OP_XOR:    result = red_any ? OUT_W'(^red_opnd) : OUT_W'(a ^ b);
                OP_ADD:    result = OUT_W'(sum);
                OP_MUL:    result = prod;
                // Shift/rotate act on the previous result, one step per sample
                OP_SHIFT:  result = direction ? {out_cur[OUT_W-2:0], serial_in}
                                              : {serial_in, out_cur[OUT_W-1:1]};
                OP_ROTATE: result = direction ? {out_cur[OUT_W-2:0], out_cur[OUT_W-1]}
                                              : {out_cur[0], out_cur[OUT_W-1:1]};
                default:   result = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alsu_param.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_param
//  Description : Two-stage parametrised arithmetic/logic/shift unit.
//                Stage 1 captures operands on in_valid; stage 2 registers the
//                result, blinks leds on invalid operations and counts them in
//                a saturating counter.
//  Ports       : clk, rst_n (async, active low), bus (alsu_param_if.slave)
//  Revision    : 1.0 - initial release
// ============================================================================
module alsu_param
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16,
    parameter int    ERR_W          = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alsu_param_if.slave  bus
);

    localparam int OUT_W = 2 * WIDTH;

    // Stage 1 registers
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       opcode_q, opcode_d;
    logic             cin_q, cin_d;
    logic             serial_in_q, serial_in_d;
    logic             direction_q, direction_d;
    logic             red_op_a_q, red_op_a_d;
    logic             red_op_b_q, red_op_b_d;
    logic             bypass_a_q, bypass_a_d;
    logic             bypass_b_q, bypass_b_d;
    logic             s1_valid_q, s1_valid_d;

    // Stage 2 registers
    logic [OUT_W-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [LED_W-1:0] leds_q, leds_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [OUT_W-1:0] dp_result;
    logic             dp_invalid;

    alsu_datapath #(
        .WIDTH          (WIDTH),
        .INPUT_PRIORITY (INPUT_PRIORITY),
        .FULL_ADDER     (FULL_ADDER)
    ) u_datapath (
        .a         (a_q),
        .b         (b_q),
        .opcode    (opcode_q),
        .cin       (cin_q),
        .serial_in (serial_in_q),
        .direction (direction_q),
        .red_op_a  (red_op_a_q),
        .red_op_b  (red_op_b_q),
        .bypass_a  (bypass_a_q),
        .bypass_b  (bypass_b_q),
        .out_cur   (out_q),
        .result    (dp_result),
        .invalid   (dp_invalid)
    );

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        opcode_d    = opcode_q;
        cin_d       = cin_q;
        serial_in_d = serial_in_q;
        direction_d = direction_q;
        red_op_a_d  = red_op_a_q;
        red_op_b_d  = red_op_b_q;
        bypass_a_d  = bypass_a_q;
        bypass_b_d  = bypass_b_q;
        if (bus.in_valid) begin
            a_d         = bus.A;
            b_d         = bus.B;
            opcode_d    = bus.opcode;
            cin_d       = bus.cin;
            serial_in_d = bus.serial_in;
            direction_d = bus.direction;
            red_op_a_d  = bus.red_op_A;
            red_op_b_d  = bus.red_op_B;
            bypass_a_d  = bus.bypass_A;
            bypass_b_d  = bus.bypass_B;
        end
        s1_valid_d = bus.in_valid;

        out_d       = out_q;
        leds_d      = leds_q;
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            out_d  = dp_result;
            leds_d = dp_invalid ? ~leds_q : '0;
        end

        // Clear wins over a same-cycle increment
        err_cnt_d = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = '0;
        end else if (s1_valid_q && dp_invalid && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            opcode_q    <= '0;
            cin_q       <= 1'b0;
            serial_in_q <= 1'b0;
            direction_q <= 1'b0;
            red_op_a_q  <= 1'b0;
            red_op_b_q  <= 1'b0;
            bypass_a_q  <= 1'b0;
            bypass_b_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            leds_q      <= '0;
            err_cnt_q   <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            opcode_q    <= opcode_d;
            cin_q       <= cin_d;
            serial_in_q <= serial_in_d;
            direction_q <= direction_d;
            red_op_a_q  <= red_op_a_d;
            red_op_b_q  <= red_op_b_d;
            bypass_a_q  <= bypass_a_d;
            bypass_b_q  <= bypass_b_d;
            s1_valid_q  <= s1_valid_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            leds_q      <= leds_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.leds      = leds_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alsu_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alsu_param
//  Description : Directed self-checking bench. dut0 uses A priority, full
//                adder on, 8-bit error counter; dut1 uses B priority, full
//                adder off, 2-bit error counter. Both see the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alsu_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       t_in_valid, t_cin, t_serial_in, t_direction;
    logic       t_red_a, t_red_b, t_byp_a, t_byp_b, t_err_clr;
    logic [2:0] t_A, t_B, t_opcode;

    int checks = 0;
    int errors = 0;

    alsu_param_if #(.WIDTH(3), .LED_W(16), .ERR_W(8)) if0 ();
    alsu_param_if #(.WIDTH(3), .LED_W(16), .ERR_W(2)) if1 ();

    assign if0.in_valid = t_in_valid;  assign if1.in_valid = t_in_valid;
    assign if0.A = t_A;                assign if1.A = t_A;
    assign if0.B = t_B;                assign if1.B = t_B;
    assign if0.opcode = t_opcode;      assign if1.opcode = t_opcode;
    assign if0.cin = t_cin;            assign if1.cin = t_cin;
    assign if0.serial_in = t_serial_in; assign if1.serial_in = t_serial_in;
    assign if0.direction = t_direction; assign if1.direction = t_direction;
    assign if0.red_op_A = t_red_a;     assign if1.red_op_A = t_red_a;
    assign if0.red_op_B = t_red_b;     assign if1.red_op_B = t_red_b;
    assign if0.bypass_A = t_byp_a;     assign if1.bypass_A = t_byp_a;
    assign if0.bypass_B = t_byp_b;     assign if1.bypass_B = t_byp_b;
    assign if0.err_clr = t_err_clr;    assign if1.err_clr = t_err_clr;

    alsu_param #(.WIDTH(3), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"),
                 .LED_W(16), .ERR_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    alsu_param #(.WIDTH(3), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"),
                 .LED_W(16), .ERR_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        t_in_valid = 0; t_cin = 0; t_serial_in = 0; t_direction = 0;
        t_red_a = 0; t_red_b = 0; t_byp_a = 0; t_byp_b = 0; t_err_clr = 0;
        t_A = 0; t_B = 0; t_opcode = 0;
    endtask

    // One accepted sample; results are visible when this returns
    task automatic send();
        t_in_valid = 1;
        step();
        t_in_valid = 0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_ctrl();
        step(); step();
        checks++; if (if0.out !== 6'd0) begin errors++; $display("FAIL rst_out0 got %0d want 0", if0.out); end
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid0 got %0b want 0", if0.out_valid); end
        checks++; if (if0.leds !== 16'h0) begin errors++; $display("FAIL rst_leds0 got %h want 0000", if0.leds); end
        checks++; if (if0.err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err0 got %0d want 0", if0.err_cnt); end
        checks++; if (if1.err_cnt !== 2'd0) begin errors++; $display("FAIL rst_err1 got %0d want 0", if1.err_cnt); end
        rst_n = 1;
        step();
    endtask

    task automatic test_bypass();
        clear_ctrl();
        t_A = 3'd5; t_B = 3'd2; t_byp_a = 1; t_byp_b = 1; t_opcode = 3'd7;
        send();
        checks++; if (if0.out !== 6'd5) begin errors++; $display("FAIL byp_both_out0 got %0d want 5", if0.out); end
        checks++; if (if1.out !== 6'd2) begin errors++; $display("FAIL byp_both_out1 got %0d want 2", if1.out); end
        checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL byp_valid0 got %0b want 1", if0.out_valid); end
        checks++; if (if0.leds !== 16'h0) begin errors++; $display("FAIL byp_leds0 got %h want 0000", if0.leds); end
        checks++; if (if0.err_cnt !== 8'd0) begin errors++; $display("FAIL byp_err0 got %0d want 0", if0.err_cnt); end
        checks++; if (if1.err_cnt !== 2'd0) begin errors++; $display("FAIL byp_err1 got %0d want 0", if1.err_cnt); end
        t_byp_a = 0; t_opcode = 3'd6;
        send();
        checks++; if (if0.out !== 6'd2) begin errors++; $display("FAIL byp_b_out0 got %0d want 2", if0.out); end
        checks++; if (if0.err_cnt !== 8'd0) begin errors++; $display("FAIL byp_b_err0 got %0d want 0", if0.err_cnt); end
    endtask

    task automatic test_arith();
        clear_ctrl();
        t_A = 3'd7; t_B = 3'd7; t_cin = 1; t_opcode = 3'd2;
        send();
        checks++; if (if0.out !== 6'd15) begin errors++; $display("FAIL add_cin_out0 got %0d want 15", if0.out); end
        checks++; if (if1.out !== 6'd14) begin errors++; $display("FAIL add_nocin_out1 got %0d want 14", if1.out); end
        t_opcode = 3'd3;
        send();
        checks++; if (if0.out !== 6'd49) begin errors++; $display("FAIL mul_out0 got %0d want 49", if0.out); end
        checks++; if (if1.out !== 6'd49) begin errors++; $display("FAIL mul_out1 got %0d want 49", if1.out); end
        t_opcode = 3'd0; t_B = 3'd0; t_red_a = 1;
        send();
        checks++; if (if0.out !== 6'd1) begin errors++; $display("FAIL and_red_a_out0 got %0d want 1", if0.out); end
        t_opcode = 3'd1; t_A = 3'd7; t_B = 3'd3; t_red_a = 1; t_red_b = 1;
        send();
        checks++; if (if0.out !== 6'd1) begin errors++; $display("FAIL xor_red_both_out0 got %0d want 1", if0.out); end
        checks++; if (if1.out !== 6'd0) begin errors++; $display("FAIL xor_red_both_out1 got %0d want 0", if1.out); end
        t_red_a = 0; t_red_b = 0; t_A = 3'd5; t_B = 3'd6; t_opcode = 3'd0;
        send();
        checks++; if (if0.out !== 6'd4) begin errors++; $display("FAIL and_out0 got %0d want 4", if0.out); end
        t_opcode = 3'd1;
        send();
        checks++; if (if0.out !== 6'd3) begin errors++; $display("FAIL xor_out0 got %0d want 3", if0.out); end
        checks++; if (if0.leds !== 16'h0) begin errors++; $display("FAIL arith_leds0 got %h want 0000", if0.leds); end
    endtask

    task automatic test_shift_rotate();
        clear_ctrl();
        t_A = 3'd4; t_B = 3'd3; t_opcode = 3'd3;
        send();
        checks++; if (if0.out !== 6'b001100) begin errors++; $display("FAIL preload_out0 got %b want 001100", if0.out); end
        t_opcode = 3'd4; t_direction = 1; t_serial_in = 1;
        send();
        checks++; if (if0.out !== 6'b011001) begin errors++; $display("FAIL shl_out0 got %b want 011001", if0.out); end
        t_opcode = 3'd5; t_direction = 0;
        send();
        checks++; if (if0.out !== 6'b101100) begin errors++; $display("FAIL ror_out0 got %b want 101100", if0.out); end
        send();
        checks++; if (if1.out !== 6'b010110) begin errors++; $display("FAIL ror2_out1 got %b want 010110", if1.out); end
        // Gap: nothing accepted, result holds
        step(); step();
        checks++; if (if0.out !== 6'b010110) begin errors++; $display("FAIL gap_out0 got %b want 010110", if0.out); end
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid0 got %0b want 0", if0.out_valid); end
    endtask

    task automatic test_back_to_back();
        clear_ctrl();
        t_opcode = 3'd4; t_direction = 1; t_serial_in = 0;
        t_in_valid = 1;
        step();
        step();
        checks++; if (if0.out !== 6'b101100) begin errors++; $display("FAIL b2b_1_out0 got %b want 101100", if0.out); end
        checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_1_valid0 got %0b want 1", if0.out_valid); end
        t_in_valid = 0;
        step();
        checks++; if (if0.out !== 6'b011000) begin errors++; $display("FAIL b2b_2_out0 got %b want 011000", if0.out); end
        checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_2_valid0 got %0b want 1", if0.out_valid); end
        step();
        checks++; if (if0.out !== 6'b011000) begin errors++; $display("FAIL b2b_hold_out0 got %b want 011000", if0.out); end
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_hold_valid0 got %0b want 0", if0.out_valid); end
    endtask

    task automatic test_invalid();
        clear_ctrl();
        t_opcode = 3'd6;
        t_in_valid = 1;
        step();
        step();
        checks++; if (if0.leds !== 16'hFFFF) begin errors++; $display("FAIL inv1_leds0 got %h want FFFF", if0.leds); end
        checks++; if (if0.out !== 6'd0) begin errors++; $display("FAIL inv1_out0 got %0d want 0", if0.out); end
        checks++; if (if0.err_cnt !== 8'd1) begin errors++; $display("FAIL inv1_err0 got %0d want 1", if0.err_cnt); end
        step();
        checks++; if (if0.leds !== 16'h0000) begin errors++; $display("FAIL inv2_leds0 got %h want 0000", if0.leds); end
        checks++; if (if1.err_cnt !== 2'd2) begin errors++; $display("FAIL inv2_err1 got %0d want 2", if1.err_cnt); end
        t_in_valid = 0;
        step();
        checks++; if (if0.leds !== 16'hFFFF) begin errors++; $display("FAIL inv3_leds0 got %h want FFFF", if0.leds); end
        checks++; if (if0.err_cnt !== 8'd3) begin errors++; $display("FAIL inv3_err0 got %0d want 3", if0.err_cnt); end
        checks++; if (if1.err_cnt !== 2'd3) begin errors++; $display("FAIL inv3_err1 got %0d want 3", if1.err_cnt); end
        step();
        checks++; if (if0.leds !== 16'hFFFF) begin errors++; $display("FAIL inv_gap_leds0 got %h want FFFF", if0.leds); end
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL inv_gap_valid0 got %0b want 0", if0.out_valid); end
        t_in_valid = 1;
        step();
        step();
        t_in_valid = 0;
        step();
        checks++; if (if0.err_cnt !== 8'd5) begin errors++; $display("FAIL inv5_err0 got %0d want 5", if0.err_cnt); end
        checks++; if (if1.err_cnt !== 2'd3) begin errors++; $display("FAIL inv5_sat_err1 got %0d want 3", if1.err_cnt); end
        checks++; if (if0.leds !== 16'hFFFF) begin errors++; $display("FAIL inv5_leds0 got %h want FFFF", if0.leds); end
        t_opcode = 3'd2; t_red_a = 1;
        send();
        checks++; if (if0.err_cnt !== 8'd6) begin errors++; $display("FAIL red_add_err0 got %0d want 6", if0.err_cnt); end
        checks++; if (if0.leds !== 16'h0000) begin errors++; $display("FAIL red_add_leds0 got %h want 0000", if0.leds); end
        clear_ctrl();
        t_opcode = 3'd6; t_byp_a = 1; t_A = 3'd3;
        send();
        checks++; if (if0.out !== 6'd3) begin errors++; $display("FAIL byp_inv_out0 got %0d want 3", if0.out); end
        checks++; if (if0.err_cnt !== 8'd6) begin errors++; $display("FAIL byp_inv_err0 got %0d want 6", if0.err_cnt); end
    endtask

    task automatic test_err_clr();
        clear_ctrl();
        t_opcode = 3'd6; t_err_clr = 1;
        send();
        t_err_clr = 0;
        checks++; if (if0.err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err0 got %0d want 0", if0.err_cnt); end
        checks++; if (if1.err_cnt !== 2'd0) begin errors++; $display("FAIL clr_err1 got %0d want 0", if1.err_cnt); end
        checks++; if (if0.leds !== 16'hFFFF) begin errors++; $display("FAIL clr_leds0 got %h want FFFF", if0.leds); end
        send();
        checks++; if (if0.err_cnt !== 8'd1) begin errors++; $display("FAIL post_clr_err0 got %0d want 1", if0.err_cnt); end
        send();
        checks++; if (if1.err_cnt !== 2'd2) begin errors++; $display("FAIL post_clr_err1 got %0d want 2", if1.err_cnt); end
        checks++; if (if0.leds !== 16'hFFFF) begin errors++; $display("FAIL post_clr_leds0 got %h want FFFF", if0.leds); end
    endtask

    task automatic test_reset_midstream();
        clear_ctrl();
        t_A = 3'd7; t_B = 3'd7; t_opcode = 3'd3;
        t_in_valid = 1;
        step();
        step();
        checks++; if (if0.out !== 6'd49) begin errors++; $display("FAIL pre_rst_out0 got %0d want 49", if0.out); end
        // Assert reset between edges with a second sample in flight
        rst_n = 0;
        #1;
        checks++; if (if0.out !== 6'd0) begin errors++; $display("FAIL async_rst_out0 got %0d want 0", if0.out); end
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid0 got %0b want 0", if0.out_valid); end
        checks++; if (if0.err_cnt !== 8'd0) begin errors++; $display("FAIL async_rst_err0 got %0d want 0", if0.err_cnt); end
        checks++; if (if1.err_cnt !== 2'd0) begin errors++; $display("FAIL async_rst_err1 got %0d want 0", if1.err_cnt); end
        checks++; if (if0.leds !== 16'h0) begin errors++; $display("FAIL async_rst_leds0 got %h want 0000", if0.leds); end
        step();
        rst_n = 1;
        step();
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL post_rel_valid0 got %0b want 0", if0.out_valid); end
        checks++; if (if0.out !== 6'd0) begin errors++; $display("FAIL post_rel_out0 got %0d want 0", if0.out); end
        t_in_valid = 0;
        step();
        checks++; if (if0.out !== 6'd49) begin errors++; $display("FAIL post_rel_new_out0 got %0d want 49", if0.out); end
        checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL post_rel_new_valid0 got %0b want 1", if0.out_valid); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_arith();
        test_shift_rotate();
        test_back_to_back();
        test_invalid();
        test_err_clr();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
